// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: round-robin TileLink channel-A arbiter with burst lock and a
// registered output stage. Define TL_ARB_PERF_EN to add per-master grant counters.
module tl_burst_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int SIZE_W      = 3,
    parameter int SOURCE_W    = 4,
    localparam int MW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_MASTERS-1:0]          io_in_valid,
    output logic [NUM_MASTERS-1:0]          io_in_ready,
    input  logic [3*NUM_MASTERS-1:0]        io_in_opcode,
    input  logic [SIZE_W*NUM_MASTERS-1:0]   io_in_size,
    input  logic [SOURCE_W*NUM_MASTERS-1:0] io_in_source,
    input  logic [ADDR_W*NUM_MASTERS-1:0]   io_in_address,
    input  logic [DATA_W*NUM_MASTERS-1:0]   io_in_data,
    output logic                            io_out_valid,
    input  logic                            io_out_ready,
    output logic [2:0]                      io_out_opcode,
    output logic [SIZE_W-1:0]               io_out_size,
    output logic [SOURCE_W-1:0]             io_out_source,
    output logic [ADDR_W-1:0]               io_out_address,
    output logic [DATA_W-1:0]               io_out_data,
    output logic [MW-1:0]                   io_out_master,
`ifdef TL_ARB_PERF_EN
    output logic [32*NUM_MASTERS-1:0]       io_perf_grants,
`endif
    output logic                            o_dbg_state
);

    // Handshake: a beat moves on valid & ready at a clock edge; ready is only
    // offered to the granted master while the output stage is free, and the
    // output beat is held unchanged while io_out_valid & !io_out_ready.

    localparam int LG_BEAT = $clog2(DATA_W / 8);
    localparam int CNT_W   = 1 << SIZE_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [MW-1:0]       r_owner, w_owner_nxt;
    logic [MW-1:0]       r_rr_ptr, w_rr_ptr_nxt;

    logic                r_out_valid;
    logic [2:0]          r_out_opcode;
    logic [SIZE_W-1:0]   r_out_size;
    logic [SOURCE_W-1:0] r_out_source;
    logic [ADDR_W-1:0]   r_out_address;
    logic [DATA_W-1:0]   r_out_data;
    logic [MW-1:0]       r_out_master;

    logic [MW-1:0]       w_rr_grant, w_grant;
    logic                w_found, w_req, w_free, w_fire, w_last;
    logic [2:0]          w_op;
    logic [SIZE_W-1:0]   w_size;
    logic [SOURCE_W-1:0] w_src;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [CNT_W-1:0]    w_beats;

    function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int k);
        return MW'((int'(base) + k) % NUM_MASTERS);
    endfunction

    // First requester after the last transfer's owner, wrapping around.
    always_comb begin
        w_found    = 1'b0;
        w_rr_grant = r_rr_ptr;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!w_found && io_in_valid[rr_idx(r_rr_ptr, k)]) begin
                w_found    = 1'b1;
                w_rr_grant = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_grant = (r_state == S_BURST) ? r_owner : w_rr_grant;
    assign w_req   = (r_state == S_BURST) | w_found;
    assign w_free  = !r_out_valid | io_out_ready;

    always_comb begin
        io_in_ready = '0;
        if (!reset && w_free && w_req) begin
            io_in_ready[w_grant] = 1'b1;
        end
    end

    assign w_fire = |(io_in_valid & io_in_ready);

    assign w_op   = io_in_opcode[int'(w_grant)*3 +: 3];
    assign w_size = io_in_size[int'(w_grant)*SIZE_W +: SIZE_W];
    assign w_src  = io_in_source[int'(w_grant)*SOURCE_W +: SOURCE_W];
    assign w_addr = io_in_address[int'(w_grant)*ADDR_W +: ADDR_W];
    assign w_data = io_in_data[int'(w_grant)*DATA_W +: DATA_W];

    // Put opcodes (0/1) carry 2^size bytes split into DATA_W-wide beats.
    always_comb begin
        w_beats = CNT_W'(1);
        if ((w_op == 3'd0 || w_op == 3'd1) && int'(w_size) > LG_BEAT) begin
            w_beats = CNT_W'(1) << (int'(w_size) - LG_BEAT);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_last         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (w_beats > CNT_W'(1)) begin
                        w_state_nxt    = S_BURST;
                        w_beat_cnt_nxt = w_beats - CNT_W'(1);
                        w_owner_nxt    = w_grant;
                    end else begin
                        w_last       = 1'b1;
                        w_rr_ptr_nxt = w_grant;
                    end
                end
            end
            S_BURST: begin
                if (w_fire) begin
                    w_beat_cnt_nxt = r_beat_cnt - CNT_W'(1);
                    if (r_beat_cnt == CNT_W'(1)) begin
                        w_state_nxt  = S_IDLE;
                        w_last       = 1'b1;
                        w_rr_ptr_nxt = r_owner;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_beat_cnt    <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= MW'(NUM_MASTERS - 1);
            r_out_valid   <= 1'b0;
            r_out_opcode  <= '0;
            r_out_size    <= '0;
            r_out_source  <= '0;
            r_out_address <= '0;
            r_out_data    <= '0;
            r_out_master  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            if (w_fire) begin
                r_out_valid   <= 1'b1;
                r_out_opcode  <= w_op;
                r_out_size    <= w_size;
                r_out_source  <= w_src;
                r_out_address <= w_addr;
                r_out_data    <= w_data;
                r_out_master  <= w_grant;
            end else if (io_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_out_valid   = r_out_valid;
    assign io_out_opcode  = r_out_opcode;
    assign io_out_size    = r_out_size;
    assign io_out_source  = r_out_source;
    assign io_out_address = r_out_address;
    assign io_out_data    = r_out_data;
    assign io_out_master  = r_out_master;
    assign o_dbg_state    = r_state;

`ifdef TL_ARB_PERF_EN
    // Completed transfers per master; wraps naturally at 32 bits.
    logic [31:0] r_perf [NUM_MASTERS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_perf[i] <= '0;
            end
        end else if (w_last) begin
            r_perf[w_grant] <= r_perf[w_grant] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_perf
        assign io_perf_grants[32*g +: 32] = r_perf[g];
    end
`endif

endmodule
